// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 inverse cipher (FIPS-197 InvCipher).
// Recovers plaintext from ciphertext produced by the AES encryptor block,
// one round per clock. The cipher key is first expanded forward to rk10.
// The round keys are then regenerated in reverse, on the fly.
//
// Ports:
//   clk     - system clock, all state updates on the rising edge
//   reset   - synchronous, active-high reset
//   cs, we  - chip select / write strobe; cs&we while idle starts a job
//   Indata  - 128-bit ciphertext, byte 0 = bits [127:120]
//   Key     - 128-bit cipher key, same byte order
//   out     - registered plaintext result
//   busy    - high from accepted start until the result is ready
//   done    - high while out holds a valid result
//
// Parameter CLR_OUT_ON_START: 1 clears out on an accepted start,
//   0 holds the previous result until the new done.
// Optional macro AES_DEC_KEY_CACHE_EN: caches the last fully expanded key
//   and its rk10. A start with the same key skips KEYEXP (12-edge latency).
module aes_decrypt #(
  parameter bit CLR_OUT_ON_START = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         we,
  input  logic [127:0] Indata,
  input  logic [127:0] Key,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINISH} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [127:0] state;
  logic [127:0] rk;
  logic [3:0]   rnd;

  logic         start;
  logic         cache_hit;
  logic [127:0] rk_load;
  logic [31:0]  sw_in, sw;
  logic [127:0] fwd_rk, rev_rk;
  logic [127:0] round_pre, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 via an add-one/double chain; 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    t = a;
    for (int i = 0; i < 6; i++) t = gf_mul(gf_mul(t, t), a);
    return gf_mul(t, t);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Undo the affine transform first, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Index 0 is the constant used to derive rk1 from rk0.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Combined InvShiftRows + InvSubBytes. Byte 4c+r is row r of column c.
  // Row r rotates right by r, so it pulls from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] =
          inv_sbox(s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  assign start = (fsm == IDLE) && cs && we;

  // One SubWord serves both directions. The forward step rotates the current
  // w3. The reverse step first rebuilds the previous w3 (w3 ^ w2).
  always_comb begin
    sw_in  = (fsm == ROUND) ? (rk[31:0] ^ rk[63:32]) : rk[31:0];
    sw     = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rcon(rnd), 24'h000000};
    fwd_rk[127:96] = rk[127:96] ^ sw;
    fwd_rk[95:64]  = rk[95:64]  ^ fwd_rk[127:96];
    fwd_rk[63:32]  = rk[63:32]  ^ fwd_rk[95:64];
    fwd_rk[31:0]   = rk[31:0]   ^ fwd_rk[63:32];
    rev_rk[31:0]   = rk[31:0]   ^ rk[63:32];
    rev_rk[63:32]  = rk[63:32]  ^ rk[95:64];
    rev_rk[95:64]  = rk[95:64]  ^ rk[127:96];
    rev_rk[127:96] = rk[127:96] ^ sw;
  end

  // The final round (r = 0) skips InvMixColumns.
  always_comb begin
    round_pre = inv_shift_sub(state) ^ rev_rk;
    round_out = (rnd != 4'd0) ? inv_mix(round_pre) : round_pre;
  end

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key, cache_rk, pend_key;
  logic         cache_valid;

  assign cache_hit = cache_valid && (Key == cache_key);
  assign rk_load   = cache_hit ? cache_rk : Key;

  // The key is held aside at start and committed only when expansion
  // completes. A job aborted by reset never touches the cache.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_key   <= '0;
      cache_rk    <= '0;
      pend_key    <= '0;
    end else begin
      if (start) pend_key <= Key;
      if (fsm == KEYEXP && rnd == 4'd9) begin
        cache_key   <= pend_key;
        cache_rk    <= fwd_rk;
        cache_valid <= 1'b1;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign rk_load   = Key;
`endif

  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (cs && we) fsm_nxt = cache_hit ? INIT : KEYEXP;
      KEYEXP:  if (rnd == 4'd9) fsm_nxt = INIT;
      INIT:    fsm_nxt = ROUND;
      ROUND:   if (rnd == 4'd0) fsm_nxt = FINISH;
      FINISH:  fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // rnd counts up 0..9 during KEYEXP (the Rcon index), then down 9..0 in ROUND.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
      rk    <= '0;
      rnd   <= 4'd0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            state <= Indata;
            rk    <= rk_load;
            rnd   <= 4'd0;
            busy  <= 1'b1;
            done  <= 1'b0;
            if (CLR_OUT_ON_START) out <= '0;
          end
        end
        KEYEXP: begin
          rk  <= fwd_rk;
          rnd <= rnd + 4'd1;
        end
        INIT: begin
          state <= state ^ rk;
          rnd   <= 4'd9;
        end
        ROUND: begin
          rk    <= rev_rk;
          state <= round_out;
          if (rnd != 4'd0) rnd <= rnd - 4'd1;
        end
        FINISH: begin
          out  <= state;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: bench for aes_decrypt using FIPS-197 vectors.
// Stimulus pushes the expected plaintext and latency into a scoreboard.
// A monitor pops and checks on every rising edge of done.
module tb_aes_decrypt;

  logic         clk = 1'b0;
  logic         reset, cs, we;
  logic [127:0] Indata, Key, out;
  logic         busy, done;

  aes_decrypt dut (
    .clk    (clk),
    .reset  (reset),
    .cs     (cs),
    .we     (we),
    .Indata (Indata),
    .Key    (Key),
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic [127:0] pt;
    int           start;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  bit           done_q = 1'b0;
  bit           cache_ok_m = 1'b0;
  logic [127:0] cache_key_m = '0;
  int           s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [127:0] got,
                              input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: each new done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 want no pending result");
      end else begin
        e = sb.pop_front();
        check_output("plaintext", out, e.pt);
        check_output("latency", 128'(cyc - e.start), 128'(e.lat));
      end
    end
    done_q = done;
  end

  function automatic int exp_lat(input logic [127:0] key);
`ifdef AES_DEC_KEY_CACHE_EN
    return (cache_ok_m && key == cache_key_m) ? 12 : 22;
`else
    return 22;
`endif
  endfunction

  // Called at a negedge. The start is sampled on the next posedge (edge 0).
  // The task returns at the following negedge with st = cycle of edge 0.
  task automatic apply_stimulus(input logic [127:0] ct, input logic [127:0] key,
                                input logic [127:0] pt, input bit track,
                                output int st);
    Indata = ct;
    Key    = key;
    cs     = 1'b1;
    we     = 1'b1;
    @(negedge clk);
    cs     = 1'b0;
    we     = 1'b0;
    Indata = ~ct;
    Key    = ~key;
    st     = cyc;
    if (track) begin
      sb.push_back('{pt: pt, start: cyc, lat: exp_lat(key)});
      cache_key_m = key;
      cache_ok_m  = 1'b1;
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check_output(name, {127'b0, done}, 128'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish want finish before 100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    cs     = 1'b0;
    we     = 1'b0;
    Indata = '0;
    Key    = '0;
    repeat (3) @(negedge clk);
    check_output("reset_out", out, 128'd0);
    check_output("reset_busy", {127'b0, busy}, 128'd0);
    check_output("reset_done", {127'b0, done}, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] App B vector");
    apply_stimulus(CT_B, KEY_B, PT_B, 1'b1, s);
    check_output("busy_after_start", {127'b0, busy}, 128'd1);
    wait_done("done_appb");
    @(negedge clk);

    $display("[TB] App C.1 vector");
    apply_stimulus(CT_C, KEY_C, PT_C, 1'b1, s);
    wait_done("done_appc");
    @(negedge clk);

    $display("[TB] start while busy is ignored");
    apply_stimulus(CT_B, KEY_B, PT_B, 1'b1, s);
    while (cyc < s + 4) @(negedge clk);
    Indata = '0;
    Key    = '0;
    cs     = 1'b1;
    we     = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    we = 1'b0;
    check_output("busy_collision", {127'b0, busy}, 128'd1);
    wait_done("done_collision");
    @(negedge clk);

    $display("[TB] reset abort");
    apply_stimulus(CT_C, KEY_C, PT_C, 1'b0, s);
    while (cyc < s + 7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cache_ok_m = 1'b0;
    check_output("abort_out", out, 128'd0);
    check_output("abort_busy", {127'b0, busy}, 128'd0);
    check_output("abort_done", {127'b0, done}, 128'd0);
    @(negedge clk);
    apply_stimulus(CT_B, KEY_B, PT_B, 1'b1, s);
    wait_done("done_after_abort");
    @(negedge clk);

    $display("[TB] back-to-back");
    apply_stimulus(CT_B, KEY_B, PT_B, 1'b1, s);
    wait_done("done_b2b_first");
    apply_stimulus(CT_C, KEY_C, PT_C, 1'b1, s);
    check_output("b2b_done_drop", {127'b0, done}, 128'd0);
    check_output("b2b_out_clear", out, 128'd0);
    check_output("b2b_busy", {127'b0, busy}, 128'd1);
    wait_done("done_b2b_second");
    @(negedge clk);

    $display("[TB] repeated key then changed key");
    apply_stimulus(CT_B, KEY_B, PT_B, 1'b1, s);
    wait_done("done_rep1");
    @(negedge clk);
    apply_stimulus(CT_B, KEY_B, PT_B, 1'b1, s);
    wait_done("done_rep2");
    @(negedge clk);
    apply_stimulus(CT_C, KEY_C, PT_C, 1'b1, s);
    wait_done("done_newkey");
    repeat (3) @(negedge clk);

    check_output("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
